// File: rtl/master_serial_port.sv
// Serial bus master: shifts a command frame out on control, then moves
// DATA_WIDTH-bit words over wD/rD, with optional bursts and a read timeout.
module master_serial_port #(
  parameter int ADDR_DEPTH = 2000,
  parameter int SLAVES     = 3,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 256,
  localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  localparam int S_ID_WIDTH = $clog2(SLAVES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic                  cmd_burst,
  input  logic [S_ID_WIDTH-1:0] cmd_slave_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  output logic                  last,
  input  logic                  rD,
  input  logic                  ready
);
  localparam int FRAME_LEN = 5 + S_ID_WIDTH + ADDR_WIDTH;
  localparam int CNT_MAX   = (FRAME_LEN > DATA_WIDTH) ? FRAME_LEN : DATA_WIDTH;
  localparam int BIT_W     = $clog2(CNT_MAX);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CTRL, W_LOAD, W_SHIFT, R_WAIT, R_SHIFT, R_ACK, FIN} state_t;

  state_t                state, next;
  logic [FRAME_LEN-1:0]  frame_sr;
  logic [BIT_W-1:0]      bit_cnt;
  logic [LEN_WIDTH-1:0]  words;
  logic [DATA_WIDTH-1:0] sr, rd_data_q;
  logic [TMO_W-1:0]      tmo;
  logic                  rw_q, burst_q, err_q;
  logic                  frame_end, word_end, tmo_hit, more, final_word;

  assign frame_end  = (bit_cnt == BIT_W'(FRAME_LEN - 1));
  assign word_end   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign tmo_hit    = (tmo == TMO_W'(TIMEOUT - 1));
  assign more       = (words != '0);
  assign final_word = burst_q && !more;
  assign rd_data    = rd_data_q;
  assign err        = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    cmd_ready = 1'b0;
    control   = 1'b0;
    wD        = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // held low while rst is high so the first ready cycle follows release
        cmd_ready = !rst;
        if (cmd_valid) next = CTRL;
      end
      CTRL: begin
        control = frame_sr[FRAME_LEN-1];
        if (frame_end) next = rw_q ? W_LOAD : R_WAIT;
      end
      W_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) next = W_SHIFT;
      end
      W_SHIFT: begin
        valid = 1'b1;
        wD    = sr[DATA_WIDTH-1];
        last  = final_word;
        if (word_end) next = more ? W_LOAD : FIN;
      end
      R_WAIT: begin
        if (ready)        next = R_SHIFT;
        else if (tmo_hit) next = FIN;
      end
      R_SHIFT: begin
        last = final_word;
        if (word_end) next = R_ACK;
      end
      R_ACK: begin
        valid    = 1'b1;
        rd_valid = 1'b1;
        next     = more ? R_WAIT : FIN;
      end
      FIN: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sr  <= '0;
      bit_cnt   <= '0;
      words     <= '0;
      sr        <= '0;
      rd_data_q <= '0;
      tmo       <= '0;
      rw_q      <= 1'b0;
      burst_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          frame_sr <= {3'b111, cmd_slave_id, cmd_rw, cmd_burst, cmd_addr};
          rw_q     <= cmd_rw;
          burst_q  <= cmd_burst;
          words    <= cmd_burst ? cmd_len : '0;
          bit_cnt  <= '0;
          tmo      <= '0;
          err_q    <= 1'b0;
        end
        CTRL: begin
          frame_sr <= frame_sr << 1;
          bit_cnt  <= frame_end ? '0 : bit_cnt + 1'b1;
        end
        W_LOAD: if (wr_valid) begin
          sr      <= wr_data;
          bit_cnt <= '0;
        end
        W_SHIFT: begin
          sr <= sr << 1;
          if (word_end) begin
            bit_cnt <= '0;
            if (more) words <= words - 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_WAIT: begin
          if (ready)        bit_cnt <= '0;
          else if (tmo_hit) err_q   <= 1'b1;
          else              tmo     <= tmo + 1'b1;
        end
        R_SHIFT: begin
          sr <= {sr[DATA_WIDTH-2:0], rD};
          if (word_end) begin
            rd_data_q <= {sr[DATA_WIDTH-2:0], rD};
            bit_cnt   <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_ACK: if (more) begin
          words <= words - 1'b1;
          tmo   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_master_serial_port.sv
// Directed bench for master_serial_port: a transaction-level model checks
// every cycle, and each transaction is also pinned by hand-computed values.
module tb_master_serial_port;
  localparam int DW = 8, AD = 2000, SL = 3, LW = 8, TMO = 20;
  localparam int AW = $clog2(AD), SW = $clog2(SL + 1), FL = 5 + SW + AW;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0, cmd_burst = 1'b0, cmd_ready;
  logic [SW-1:0] cmd_slave_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic wr_valid = 1'b0, wr_ready, rd_valid, done, err;
  logic control, wD, valid, last, rD = 1'b0, ready = 1'b0;

  always #5 clk = ~clk;

  master_serial_port #(.ADDR_DEPTH(AD), .SLAVES(SL), .DATA_WIDTH(DW),
                       .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_burst(cmd_burst), .cmd_slave_id(cmd_slave_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .err(err), .control(control),
    .wD(wD), .valid(valid), .last(last), .rD(rD), .ready(ready));

  int vecs = 0, bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [FL-1:0] frame; bit rw; bit burst; bit err; } txn_t;
  typedef struct {
    logic [FL-1:0] ctrl; logic [DW-1:0] wword, rword;
    int cycles, vcnt, lcnt; bit err;
  } log_t;

  txn_t pend[$];
  logic [1:0] wq[$];          // {wD, last} per expected write bit
  logic [DW-1:0] rq[$];
  log_t txn_log[$];
  int done_cnt = 0;
  logic [DW-1:0] wdat[4], rdat[4];

  // Model/compare process: outputs sampled mid-cycle on the falling edge.
  txn_t cur;
  log_t lg;
  bit busy = 0;
  int fcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outs", 32'({control, wD, valid, last, rd_valid, done, err, wr_ready, cmd_ready}), 0);
      chk("reset_rd_data", 32'(rd_data), 0);
      busy = 0; fcnt = 0;
      pend.delete(); wq.delete(); rq.delete();
    end else begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      chk("control", 32'(control), 32'(fcnt > 0 ? cur.frame[fcnt-1] : 1'b0));
      if (fcnt > 0) begin
        lg.ctrl = {lg.ctrl[FL-2:0], control};
        fcnt--;
      end
      if (busy) begin
        lg.cycles++;
        if (last) lg.lcnt++;
        if (valid) begin
          lg.vcnt++;
          if (cur.rw) begin
            chk("wbit_expected", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) chk("wD_last", 32'({wD, last}), 32'(wq.pop_front()));
            lg.wword = {lg.wword[DW-2:0], wD};
          end else begin
            chk("rd_valid_with_valid", 32'(rd_valid), 1);
            chk("rword_expected", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) chk("rd_data", 32'(rd_data), 32'(rq.pop_front()));
            lg.rword = rd_data;
          end
        end else begin
          chk("rd_valid_quiet", 32'(rd_valid), 0);
          if (cur.rw) chk("last_no_valid", 32'(last), 0);
        end
        if (!cur.rw) chk("wr_ready_read", 32'(wr_ready), 0);
        if (done) begin
          chk("err_at_done", 32'(err), 32'(cur.err));
          chk("wbits_drained", wq.size(), 0);
          chk("rwords_drained", rq.size(), 0);
          if (!cur.rw) chk("read_last_cycles", lg.lcnt, cur.burst ? DW : 0);
          lg.err = err;
          txn_log.push_back(lg);
          busy = 0;
          done_cnt++;
        end
      end else begin
        chk("idle_quiet", 32'({valid, done, rd_valid, wr_ready, last}), 0);
      end
      if (cmd_valid && cmd_ready) begin
        chk("cmd_expected", 32'(pend.size() != 0), 1);
        if (pend.size() != 0) begin
          cur = pend.pop_front();
          busy = 1; fcnt = FL;
          lg.ctrl = '0; lg.wword = '0; lg.rword = '0;
          lg.cycles = 0; lg.vcnt = 0; lg.lcnt = 0; lg.err = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic issue(bit rw, bit burst, int id, int addr, int len, bit exp_err);
    txn_t t;
    t.frame = {3'b111, SW'(id), rw, burst, AW'(addr)};
    t.rw = rw; t.burst = burst; t.err = exp_err;
    pend.push_back(t);
    cmd_rw = rw; cmd_burst = burst; cmd_slave_id = SW'(id);
    cmd_addr = AW'(addr); cmd_len = LW'(len); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(string name, int d0);
    int k = 0;
    while (done_cnt == d0 && k < 500) begin tick(); k++; end
    chk({name, "_done_seen"}, 32'(done_cnt != d0), 1);
  endtask

  // A gap holds wr_valid low in W_LOAD; a stray command is offered meanwhile.
  task automatic send_word(logic [DW-1:0] d, int gap);
    int k = 0;
    while (!wr_ready && k < 100) begin tick(); k++; end
    if (gap > 0) cmd_valid = 1'b1;
    repeat (gap) tick();
    cmd_valid = 1'b0;
    wr_data = d; wr_valid = 1'b1;
    k = 0;
    while (!wr_ready && k < 100) begin tick(); k++; end
    chk("wr_ready_seen", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_txn(int id, int addr, bit burst, int len, int gap_word, int gap);
    int d0 = done_cnt;
    int nw = burst ? len + 1 : 1;
    for (int w = 0; w < nw; w++)
      for (int b = DW - 1; b >= 0; b--)
        wq.push_back({wdat[w][b], burst && (w == nw - 1)});
    issue(1'b1, burst, id, addr, len, 1'b0);
    for (int w = 0; w < nw; w++) send_word(wdat[w], (w == gap_word) ? gap : 0);
    wait_done("write", d0);
  endtask

  // Slave side: ready after `delay` idle cycles, then the word MSB first.
  task automatic read_txn(int id, int addr, bit burst, int len, int delay, bit tmo);
    int d0 = done_cnt;
    int nw = burst ? len + 1 : 1;
    if (!tmo) for (int w = 0; w < nw; w++) rq.push_back(rdat[w]);
    issue(1'b0, burst, id, addr, len, tmo);
    if (!tmo) begin
      repeat (FL) tick();
      for (int w = 0; w < nw; w++) begin
        repeat (delay) tick();
        ready = 1'b1; tick(); ready = 1'b0;
        for (int b = DW - 1; b >= 0; b--) begin rD = rdat[w][b]; tick(); end
        rD = 1'b0; tick();
      end
    end
    wait_done("read", d0);
  endtask

  log_t r;
  int d0;
  initial begin
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single write, id 1, addr 5
    wdat[0] = 8'hA5;
    write_txn(1, 5, 1'b0, 0, -1, 0);
    r = txn_log[$];
    chk("t1_frame", 32'(r.ctrl), 32'(18'b111_01_1_0_00000000101));
    chk("t1_word", 32'(r.wword), 32'h A5);
    chk("t1_cycles", r.cycles, 28);
    chk("t1_valid_cycles", r.vcnt, 8);
    chk("t1_last_cycles", r.lcnt, 0);

    // single read, slave ready after 3 cycles; wr_valid held high throughout
    wr_data = 8'hFF; wr_valid = 1'b1;
    rdat[0] = 8'h3C;
    read_txn(2, 7, 1'b0, 0, 3, 1'b0);
    wr_valid = 1'b0;
    r = txn_log[$];
    chk("t2_frame", 32'(r.ctrl), 32'(18'b111_10_0_0_00000000111));
    chk("t2_rd_data", 32'(r.rword), 32'h3C);
    chk("t2_valid_pulses", r.vcnt, 1);
    chk("t2_err", 32'(r.err), 0);
    chk("t2_cycles", r.cycles, 32);

    // burst write of three words, 4-cycle gap before the second
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    write_txn(0, 100, 1'b1, 2, 1, 4);
    r = txn_log[$];
    chk("t3_last_word", 32'(r.wword), 32'h33);
    chk("t3_last_cycles", r.lcnt, 8);
    chk("t3_valid_cycles", r.vcnt, 24);
    chk("t3_cycles", r.cycles, 50);

    // read timeout
    read_txn(3, 0, 1'b0, 0, 0, 1'b1);
    r = txn_log[$];
    chk("t4_err", 32'(r.err), 1);
    chk("t4_valid_pulses", r.vcnt, 0);
    chk("t4_cycles", r.cycles, FL + TMO + 1);

    // two-word read burst at the top address
    rdat[0] = 8'hC3; rdat[1] = 8'h96;
    read_txn(1, 1999, 1'b1, 1, 1, 1'b0);
    r = txn_log[$];
    chk("t5_valid_pulses", r.vcnt, 2);
    chk("t5_last_cycles", r.lcnt, 8);
    chk("t5_second_word", 32'(r.rword), 32'h96);
    chk("t5_err_cleared", 32'(r.err), 0);
    chk("t5_cycles", r.cycles, 41);

    // burst=0 ignores cmd_len; burst with len 0 is one last word
    wdat[0] = 8'h3C;
    write_txn(2, 42, 1'b0, 5, -1, 0);
    r = txn_log[$];
    chk("t6_valid_cycles", r.vcnt, 8);
    chk("t6_last_cycles", r.lcnt, 0);
    wdat[0] = 8'h81;
    write_txn(0, 0, 1'b1, 0, -1, 0);
    r = txn_log[$];
    chk("t7_valid_cycles", r.vcnt, 8);
    chk("t7_last_cycles", r.lcnt, 8);

    // reset at bit 4 of a write word
    d0 = done_cnt;
    for (int b = DW - 1; b >= 0; b--) wq.push_back({wdat[0][b], 1'b0});
    issue(1'b1, 1'b0, 1, 5, 0, 1'b0);
    send_word(8'h81, 0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("t8_outs_on_rst", 32'({control, wD, valid, last, rd_valid, done, err, wr_ready, cmd_ready}), 0);
    chk("t8_rd_data_on_rst", 32'(rd_data), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t8_no_done", done_cnt, d0);
    wdat[0] = 8'h5A;
    write_txn(1, 5, 1'b0, 0, -1, 0);
    r = txn_log[$];
    chk("t8_word_after_rst", 32'(r.wword), 32'h5A);
    chk("t8_cycles_after_rst", r.cycles, 28);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/master_serial_port.md
MASTER_SERIAL_PORT -- requirements
Module: master_serial_port

Interface
REQ-001 Parameter ADDR_DEPTH, default 2000, slave memory depth; ADDR_WIDTH = $clog2(ADDR_DEPTH).
REQ-002 Parameter SLAVES, default 3, number of slaves; S_ID_WIDTH = $clog2(SLAVES+1).
REQ-003 Parameter DATA_WIDTH, default 32, serial word length.
REQ-004 Parameter LEN_WIDTH, default 8, burst word-count width.
REQ-005 Parameter TIMEOUT, default 256, maximum cycles to wait for slave ready on a read.
REQ-006 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 Port rst, input, 1, asynchronous, active-high reset.
REQ-008 Port cmd_valid / cmd_ready, input / output, 1 / 1, command handshake.
REQ-009 Port cmd_rw, input, 1: 1 = write, 0 = read.
REQ-010 Port cmd_burst, input, 1, burst request.
REQ-011 Port cmd_slave_id, input, S_ID_WIDTH, target slave.
REQ-012 Port cmd_addr, input, ADDR_WIDTH, start address.
REQ-013 Port cmd_len, input, LEN_WIDTH, words minus one; ignored when cmd_burst=0.
REQ-014 Port wr_data / wr_valid / wr_ready, input / input / output, DATA_WIDTH / 1 / 1, write-word handshake.
REQ-015 Port rd_data / rd_valid, output / output, DATA_WIDTH / 1, received word plus one-cycle strobe.
REQ-016 Port done / err, output / output, 1 / 1, one-cycle end-of-transaction strobe; err valid with done.
REQ-017 Port control, wD, valid, last, output, 1 each, serial bus toward slave.
REQ-018 Port rD, ready, input, 1 each, serial bus from slave.

Function
REQ-019 Frame SHALL be {3'b111, slave_id, rw, burst, addr}, FRAME_LEN = 5+S_ID_WIDTH+ADDR_WIDTH bits, sent MSB first on control, one bit per cycle.
REQ-020 States SHALL be IDLE, CTRL, W_LOAD, W_SHIFT, R_WAIT, R_SHIFT, R_ACK, FIN.
REQ-021 IDLE: cmd_ready=1, control=0; on cmd_valid, latch command into frame register and word counter, go to CTRL.
REQ-022 CTRL: drive control for exactly FRAME_LEN cycles, then control=0; go to W_LOAD if rw=1, else R_WAIT.
REQ-023 W_LOAD: wr_ready=1; on wr_valid, load shift register with wr_data, go to W_SHIFT; valid=0 while waiting.
REQ-024 W_SHIFT: valid=1, wD = shift MSB, shift left each cycle for DATA_WIDTH cycles; last=1 for all bits of the final word when burst=1.
REQ-025 After the final bit: if words remain, decrement counter and go to W_LOAD; else go to FIN.
REQ-026 R_WAIT: wait for ready=1 then go to R_SHIFT; timeout counter increments each cycle; reaching TIMEOUT sets err and goes to FIN with valid never asserted.
REQ-027 R_SHIFT: sample rD into shift register LSB, shift left, for DATA_WIDTH cycles (MSB first); last=1 during final word when burst=1.
REQ-028 R_ACK: one cycle, valid=1, rd_data = assembled word, rd_valid=1; then R_WAIT (timeout cleared) if words remain, else FIN.
REQ-029 FIN: done=1 for one cycle, err reported, return to IDLE; err clears on next accepted command.
REQ-030 cmd_burst=0 SHALL transfer exactly one word regardless of cmd_len; cmd_len=0 with burst=1 transfers one word with last=1.
REQ-031 cmd_valid outside IDLE SHALL be ignored; wr_valid outside W_LOAD SHALL be ignored.
REQ-032 Word counter SHALL not wrap; address increment is the slave's responsibility.

Reset
REQ-033 rst asserted SHALL immediately force IDLE; control, wD, valid, last, rd_valid, done, err, wr_ready = 0; rd_data, shift registers, counters = 0; cmd_ready=1 on first cycle after release.
REQ-034 rst mid-transaction SHALL abort with no done strobe; bus outputs low the same cycle.

Verification
REQ-035 DATA_WIDTH=8, ADDR_WIDTH=11, S_ID_WIDTH=2: write, id=1, addr=5, no burst, wr_data=0xA5 -> control 111_01_1_0_00000000101 over 18 cycles; wD 10100101 with valid=1 for 8 cycles; last=0; done=1.
REQ-036 Read, id=2, addr=7, slave ready after 3 cycles, rD=0x3C serial -> rd_data=0x3C, rd_valid and valid pulse 1 cycle, done, err=0.
REQ-037 Write burst cmd_len=2, data 0x11,0x22,0x33, wr_valid delayed 4 cycles on word 2 -> valid=0 during gap; last=1 only during 0x33 bits.
REQ-038 Read with ready held 0 -> err=1, done after TIMEOUT cycles, valid never 1.
REQ-039 rst asserted at bit 4 of write word -> all outputs 0 immediately; new command after release completes normally.
REQ-040 Read burst cmd_len=1 -> two rd_valid strobes, last=1 during second word only.
